csr_access_responder: RTL

- Machine-mode CSR responder at the other end of the exception handler's CSR access and trap/return interface.
- Services CSR read-modify-write requests with a two-cycle READ/MODIFY sequence.
- Commits trap-entry and MRET state updates to mstatus/mepc/mcause/mtval.
- Exports mtvec, mepc and the global interrupt enable to fetch/commit logic.

---
 rtl/csr_access_responder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/csr_access_responder.sv
// Machine-mode CSR responder: two-cycle READ/MODIFY servicing of CSR requests
// plus trap-entry and MRET commits to mstatus/mepc/mcause/mtval.
module csr_access_responder #(
   parameter int unsigned     XLEN        = 64,
   parameter logic [XLEN-1:0] HART_ID     = '0,
   parameter logic [XLEN-1:0] MISA_VALUE  = 64'h8000_0000_0014_1101,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic            clock_i,
   input  logic            reset_ni,
   input  logic            csr_req_valid_i,
   output logic            csr_req_ready_o,
   input  logic [1:0]      csr_op_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic            csr_rsp_valid_o,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            csr_illegal_o,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic [XLEN-1:0] trap_tval_i,
   input  logic            mret_i,
   output logic            event_ack_o,
   output logic [XLEN-1:0] mtvec_o,
   output logic [XLEN-1:0] mepc_o,
   output logic            mie_o
);

   localparam logic [1:0] OP_READ = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;
   localparam logic [1:0] OP_RC   = 2'b11;

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MISA     = 12'h301;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MTVAL    = 12'h343;
   localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

   localparam int NUM_CSRS = 8;
   localparam logic [11:0] CSR_ADDR [NUM_CSRS] = '{
      ADDR_MSTATUS, ADDR_MISA, ADDR_MTVEC, ADDR_MSCRATCH,
      ADDR_MEPC, ADDR_MCAUSE, ADDR_MTVAL, ADDR_MHARTID
   };
   // Bit i set when CSR_ADDR[i] is read-only (misa, mhartid).
   localparam logic [NUM_CSRS-1:0] CSR_RO = 8'b1000_0010;

   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_READ, ST_MODIFY} state_t;

   state_t            state_reg, state_next;
   logic [1:0]        op_reg;
   logic [11:0]       addr_reg;
   logic [XLEN-1:0]   wdata_reg;
   logic [XLEN-1:0]   old_reg;
   logic              illegal_reg;
   logic              mie_reg, mpie_reg;
   logic [XLEN-1:0]   mtvec_reg, mscratch_reg, mepc_reg, mcause_reg, mtval_reg;

   logic [NUM_CSRS-1:0] addr_hit;
   logic [XLEN-1:0]     rd_value, mstatus_value, new_value;
   logic                rd_illegal, write_attempt;
   logic                accept, trap_commit, mret_commit, csr_write;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CSRS; gi++) begin : g_addr_hit
         assign addr_hit[gi] = (addr_reg == CSR_ADDR[gi]);
      end
   endgenerate

   // RS/RC with a zero operand is a pure read, so only a nonzero mask counts as a write.
   assign write_attempt = (op_reg == OP_RW) || ((op_reg == OP_RS || op_reg == OP_RC) && (wdata_reg != '0));
   assign rd_illegal    = (addr_hit == '0) || (((addr_hit & CSR_RO) != '0) && write_attempt);

   always_comb begin
      mstatus_value        = '0;
      mstatus_value[12:11] = 2'b11;
      mstatus_value[7]     = mpie_reg;
      mstatus_value[3]     = mie_reg;
   end

   always_comb begin
      rd_value = '0;
      case (addr_reg)
         ADDR_MSTATUS:  rd_value = mstatus_value;
         ADDR_MISA:     rd_value = MISA_VALUE;
         ADDR_MTVEC:    rd_value = mtvec_reg;
         ADDR_MSCRATCH: rd_value = mscratch_reg;
         ADDR_MEPC:     rd_value = mepc_reg;
         ADDR_MCAUSE:   rd_value = mcause_reg;
         ADDR_MTVAL:    rd_value = mtval_reg;
         ADDR_MHARTID:  rd_value = HART_ID;
         default:       rd_value = '0;
      endcase
   end

   always_comb begin
      new_value = wdata_reg;
      case (op_reg)
         OP_RS:   new_value = old_reg | wdata_reg;
         OP_RC:   new_value = old_reg & ~wdata_reg;
         default: new_value = wdata_reg;
      endcase
   end

   always_comb begin
      state_next      = state_reg;
      csr_req_ready_o = 1'b0;
      csr_rsp_valid_o = 1'b0;
      event_ack_o     = 1'b0;
      case (state_reg)
         ST_RESET: state_next = ST_IDLE;
         ST_IDLE: begin
            csr_req_ready_o = !trap_i && !mret_i;
            event_ack_o     = trap_i || mret_i;
            if (csr_req_valid_i && csr_req_ready_o) begin
               state_next = ST_READ;
            end
         end
         ST_READ:  state_next = ST_MODIFY;
         ST_MODIFY: begin
            csr_rsp_valid_o = 1'b1;
            state_next      = ST_IDLE;
         end
         default:  state_next = ST_RESET;
      endcase
   end

   assign accept      = csr_req_valid_i && csr_req_ready_o;
   assign trap_commit = (state_reg == ST_IDLE) && trap_i;
   assign mret_commit = (state_reg == ST_IDLE) && !trap_i && mret_i;
   assign csr_write   = (state_reg == ST_MODIFY) && !illegal_reg && (op_reg != OP_READ);

   assign csr_rdata_o   = csr_rsp_valid_o ? old_reg : '0;
   assign csr_illegal_o = csr_rsp_valid_o && illegal_reg;
   assign mtvec_o       = mtvec_reg;
   assign mepc_o        = mepc_reg;
   assign mie_o         = mie_reg;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_reg    <= ST_RESET;
         op_reg       <= OP_READ;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         old_reg      <= '0;
         illegal_reg  <= 1'b0;
         mie_reg      <= 1'b0;
         mpie_reg     <= 1'b0;
         mtvec_reg    <= MTVEC_RESET & ALIGN_MASK;
         mscratch_reg <= '0;
         mepc_reg     <= '0;
         mcause_reg   <= '0;
         mtval_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg    <= csr_op_i;
            addr_reg  <= csr_addr_i;
            wdata_reg <= csr_wdata_i;
         end
         // Illegal requests answer with zero data, so capture zero up front.
         if (state_reg == ST_READ) begin
            old_reg     <= rd_illegal ? '0 : rd_value;
            illegal_reg <= rd_illegal;
         end
         if (trap_commit) begin
            mepc_reg   <= trap_pc_i & ALIGN_MASK;
            mcause_reg <= trap_cause_i;
            mtval_reg  <= trap_tval_i;
            mpie_reg   <= mie_reg;
            mie_reg    <= 1'b0;
         end else if (mret_commit) begin
            mie_reg  <= mpie_reg;
            mpie_reg <= 1'b1;
         end else if (csr_write) begin
            case (addr_reg)
               ADDR_MSTATUS: begin
                  mie_reg  <= new_value[3];
                  mpie_reg <= new_value[7];
               end
               ADDR_MTVEC:    mtvec_reg    <= new_value & ALIGN_MASK;
               ADDR_MSCRATCH: mscratch_reg <= new_value;
               ADDR_MEPC:     mepc_reg     <= new_value & ALIGN_MASK;
               ADDR_MCAUSE:   mcause_reg   <= new_value;
               ADDR_MTVAL:    mtval_reg    <= new_value;
               default: ;
            endcase
         end
      end
   end

endmodule
